// File: rtl/fan_line_packer_if.sv
// Handshake bundle between the partial-product producer, the FAN line packer
// and the first adder stage. slave is the packer's view, master the environment's.
interface fan_line_packer_if #(
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_LINE = 16,
  parameter int NUM_IN  = 4
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [DW_DATA-1:0]        in_data;
  logic [DW_ROW-1:0]         in_row;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_IN*DW_LINE-1:0] out;

  modport slave (
    input  in_valid, in_data, in_row, in_last, out_ready,
    output in_ready, out_valid, out
  );

  modport master (
    output in_valid, in_data, in_row, in_last, out_ready,
    input  in_ready, out_valid, out
  );
endinterface

// File: rtl/fan_line_packer.sv
// Packs a serial stream of row-tagged products into NUM_IN-lane FAN line groups.
// Optional macro FAN_PACK_STATS_EN adds stat_groups/stat_lines transfer counters.
module fan_line_packer #(
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
  parameter int NUM_IN  = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FAN_PACK_STATS_EN
  output logic [15:0]        stat_groups,
  output logic [15:0]        stat_lines,
`endif
  fan_line_packer_if.slave   bus
);
  localparam int CNT_W = $clog2(NUM_IN + 1);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]                state;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          grp_count;
  logic [DW_DATA-1:0]        fill_data [NUM_IN];
  logic [DW_ROW-1:0]         fill_row  [NUM_IN];
  logic [DW_DATA-1:0]        lane_data [NUM_IN];
  logic [DW_ROW-1:0]         lane_row  [NUM_IN];
  logic [DW_CTRL-1:0]        lane_ctrl [NUM_IN];
  logic [NUM_IN-1:0]         lane_valid;
  logic [NUM_IN-1:0]         same_next;
  logic [NUM_IN-1:0]         link_hi;
  logic [NUM_IN-1:0]         link_lo;
  logic [NUM_IN-1:0]         keep;
  logic [NUM_IN*DW_LINE-1:0] group_lines;
  logic [NUM_IN*DW_LINE-1:0] out_q;
  logic                      out_valid_q;
  logic                      in_ready;
  logic                      accept;
  logic                      close;
  logic                      out_free;
  logic                      transfer;

  assign in_ready      = (state == ST_FILL);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

  assign accept    = bus.in_valid && in_ready;
  assign grp_count = accept ? count + CNT_W'(1) : count;
  assign close     = accept && ((grp_count == CNT_W'(NUM_IN)) || bus.in_last);
  assign out_free  = !out_valid_q || bus.out_ready;
  assign transfer  = out_free && ((state == ST_FULL) || close);

  // The group view merges the product being accepted this cycle so a close can transfer on the same edge.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign lane_valid[i] = CNT_W'(i) < grp_count;
    assign lane_data[i]  = (accept && count == CNT_W'(i)) ? bus.in_data : fill_data[i];
    assign lane_row[i]   = (accept && count == CNT_W'(i)) ? bus.in_row  : fill_row[i];

    if (i < NUM_IN - 1) begin : g_pair
      assign same_next[i] = lane_valid[i] && lane_valid[i+1] && (lane_row[i] == lane_row[i+1]);
    end else begin : g_top
      assign same_next[i] = 1'b0;
    end

    if (i == 0) begin : g_bottom
      assign link_lo[i] = 1'b0;
    end else begin : g_lower
      assign link_lo[i] = same_next[i-1];
    end

    assign link_hi[i]   = same_next[i];
    assign keep[i]      = lane_valid[i] && !link_lo[i] && !link_hi[i];
    assign lane_ctrl[i] = DW_CTRL'({lane_valid[i], keep[i], link_hi[i], link_lo[i]});
    assign group_lines[i*DW_LINE +: DW_LINE] =
      lane_valid[i] ? {lane_ctrl[i], lane_row[i], lane_data[i]} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        fill_data[i] <= '0;
        fill_row[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (accept && count == CNT_W'(i)) begin
          fill_data[i] <= bus.in_data;
          fill_row[i]  <= bus.in_row;
        end
      end

      if (transfer) begin
        count <= '0;
        state <= ST_FILL;
      end else if (close) begin
        count <= grp_count;
        state <= ST_FULL;
      end else if (accept) begin
        count <= grp_count;
      end

      // A transfer during a drain reloads the register, so out_valid never dips.
      if (transfer) begin
        out_q       <= group_lines;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef FAN_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_groups <= '0;
      stat_lines  <= '0;
    end else if (transfer) begin
      stat_groups <= stat_groups + 16'd1;
      stat_lines  <= stat_lines + 16'(grp_count);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fan_line_packer.sv
// Randomized self-checking bench for fan_line_packer against a queue-based group model.
// Define FAN_PACK_STATS_EN to also exercise the statistics counters.
module tb_fan_line_packer;
  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
  localparam int NUM_IN  = 4;
  localparam int GW      = NUM_IN * DW_LINE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fan_line_packer_if #(.DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_LINE(DW_LINE), .NUM_IN(NUM_IN)) bus ();

`ifdef FAN_PACK_STATS_EN
  logic [15:0] stat_groups;
  logic [15:0] stat_lines;
`endif

  fan_line_packer #(
    .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_CTRL(DW_CTRL), .DW_LINE(DW_LINE), .NUM_IN(NUM_IN)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef FAN_PACK_STATS_EN
    .stat_groups(stat_groups),
    .stat_lines(stat_lines),
`endif
    .bus(bus)
  );

  // Reference model: products collect into a group; a full or last-tagged group becomes an expected word.
  logic [DW_ROW-1:0]  cur_rows[$];
  logic [DW_DATA-1:0] cur_data[$];
  logic [GW-1:0]      exp_q[$];

  function automatic void model_reset();
    cur_rows.delete();
    cur_data.delete();
    exp_q.delete();
  endfunction

  function automatic void model_accept(input logic [DW_ROW-1:0] row, input logic [DW_DATA-1:0] data,
                                       input logic last);
    logic [GW-1:0] g;
    logic hi, lo;
    int n;
    cur_rows.push_back(row);
    cur_data.push_back(data);
    if (cur_rows.size() == NUM_IN || last) begin
      g = '0;
      n = cur_rows.size();
      for (int i = 0; i < n; i++) begin
        hi = 1'b0;
        lo = 1'b0;
        if (i + 1 < n) hi = (cur_rows[i] == cur_rows[i+1]);
        if (i > 0)     lo = (cur_rows[i-1] == cur_rows[i]);
        g[i*DW_LINE +: DW_LINE] = {1'b1, !hi && !lo, hi, lo, cur_rows[i], cur_data[i]};
      end
      exp_q.push_back(g);
      cur_rows.delete();
      cur_data.delete();
    end
  endfunction

  // One clock of stimulus; reports what the DUT showed just before the edge.
  task automatic step(input logic v, input logic [DW_ROW-1:0] row, input logic [DW_DATA-1:0] data,
                      input logic last, input logic rdy,
                      output logic acc, output logic drn, output logic ov, output logic [GW-1:0] word);
    bus.in_valid  = v;
    bus.in_row    = row;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.out_ready = rdy;
    #1;
    acc  = v && bus.in_ready;
    ov   = bus.out_valid;
    drn  = bus.out_valid && rdy;
    word = bus.out;
    @(posedge clk);
    #1;
    if (acc) model_accept(row, data, last);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    vectors++;
    if (bus.out !== '0) begin
      miscompares++; $display("[TB] FAIL reset_out: got %h expected 0", bus.out);
    end
  endtask

  task automatic test_basic();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    logic [GW-1:0] want;
    logic [DW_ROW-1:0] rows [4] = '{4'd2, 4'd2, 4'd3, 4'd5};
    want = {4'b1100, 4'd5, 8'd4, 4'b1100, 4'd3, 8'd3, 4'b1001, 4'd2, 8'd2, 4'b1010, 4'd2, 8'd1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rows[i], 8'(i + 1), 1'b0, 1'b1, acc, drn, ov, word);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++; $display("[TB] FAIL basic_accept[%0d]: got %b expected 1", i, acc);
      end
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++; $display("[TB] FAIL basic_latency: out_valid got %b expected 1", bus.out_valid);
    end
    vectors++;
    if (bus.out !== want) begin
      miscompares++; $display("[TB] FAIL basic_lines: got %h expected %h", bus.out, want);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    vectors++;
    if (!drn || exp_q.size() == 0 || word !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL basic_drain: drained %b word %h expected %h", drn, word, want);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_last();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    logic [GW-1:0] want;
    want = {32'h0, 4'b1001, 4'd7, 8'd5, 4'b1010, 4'd7, 8'd9};
    step(1'b1, 4'd7, 8'd9, 1'b0, 1'b1, acc, drn, ov, word);
    step(1'b1, 4'd7, 8'd5, 1'b1, 1'b1, acc, drn, ov, word);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== want) begin
      miscompares++;
      $display("[TB] FAIL last_close: valid %b out %h expected valid 1 out %h", bus.out_valid, bus.out, want);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    vectors++;
    if (!drn || exp_q.size() == 0 || word !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL last_drain: drained %b word %h expected %h", drn, word, want);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_backpressure();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'($urandom_range(3, 0)), 8'($urandom), 1'b0, 1'b0, acc, drn, ov, word);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++; $display("[TB] FAIL bp_accept[%0d]: got %b expected 1", i, acc);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd1, 8'd1, 1'b0, 1'b0, acc, drn, ov, word);
      vectors++;
      if (acc !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== exp_q[0]) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: acc %b ready %b valid %b out %h expected acc 0 ready 0 valid 1 out %h",
                 i, acc, bus.in_ready, bus.out_valid, bus.out, exp_q[0]);
      end
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    vectors++;
    if (!drn || word !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL bp_drain1: drained %b word %h expected %h", drn, word, exp_q[0]);
    end
    void'(exp_q.pop_front());
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out !== exp_q[0]) begin
      miscompares++;
      $display("[TB] FAIL bp_group2: valid %b ready %b out %h expected valid 1 ready 1 out %h",
               bus.out_valid, bus.in_ready, bus.out, exp_q[0]);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    vectors++;
    if (!drn || word !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL bp_drain2: drained %b word %h expected %h", drn, word, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_stream();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    int drains = 0;
    for (int i = 0; i < 8 * NUM_IN; i++) begin
      step(1'b1, 4'($urandom_range(3, 0)), 8'($urandom), 1'b0, 1'b1, acc, drn, ov, word);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++; $display("[TB] FAIL stream_bubble[%0d]: accept got %b expected 1", i, acc);
      end
      if (drn) begin
        drains++;
        vectors++;
        if (exp_q.size() == 0 || word !== exp_q[0]) begin
          miscompares++; $display("[TB] FAIL stream_group: got %h expected %h", word, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    vectors++;
    if (drains != 7) begin
      miscompares++; $display("[TB] FAIL stream_rate: groups %0d expected 7", drains);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    vectors++;
    if (!drn || exp_q.size() == 0 || word !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL stream_tail: drained %b word %h", drn, word);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'd6, 8'(8'hA0 + i), 1'b0, 1'b1, acc, drn, ov, word);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: valid %b ready %b expected valid 0 ready 1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(i % 2), 8'(8'h10 + i), 1'b0, 1'b1, acc, drn, ov, word);
    vectors++;
    if (bus.out_valid !== 1'b1 || exp_q.size() != 1 || bus.out !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL midreset_fresh: valid %b out %h expected %h", bus.out_valid, bus.out, exp_q[0]);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    logic held = 1'b0;
    logic [GW-1:0] held_word = '0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99, 0) < 70, 4'($urandom_range(3, 0)), 8'($urandom),
           $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 60, acc, drn, ov, word);
      if (held) begin
        vectors++;
        if (ov !== 1'b1 || word !== held_word) begin
          miscompares++; $display("[TB] FAIL random_stable[%0d]: valid %b out %h expected valid 1 out %h", i, ov, word, held_word);
        end
      end
      held = ov && !drn;
      held_word = word;
      if (drn) begin
        vectors++;
        if (exp_q.size() == 0 || word !== exp_q[0]) begin
          miscompares++; $display("[TB] FAIL random_group[%0d]: got %h expected %h", i, word, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++)
      step(1'b1, 4'd3, 8'h55, 1'b1, 1'b1, acc, drn, ov, word);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && (exp_q.size() > 0 || bus.out_valid); i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
      if (drn) begin
        vectors++;
        if (exp_q.size() == 0 || word !== exp_q[0]) begin
          miscompares++; $display("[TB] FAIL random_flush: got %h expected %h", word, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    vectors++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL random_timeout: pending %0d valid %b expected 0 0", exp_q.size(), bus.out_valid);
    end
  endtask

`ifdef FAN_PACK_STATS_EN
  task automatic test_stats();
    logic acc, drn, ov;
    logic [GW-1:0] word;
    do_reset();
    test_basic();
    test_last();
    vectors++;
    if (stat_groups !== 16'd2 || stat_lines !== 16'd6) begin
      miscompares++; $display("[TB] FAIL stats_count: groups %0d lines %0d expected 2 6", stat_groups, stat_lines);
    end
    for (int i = 0; i < 65534; i++) begin
      step(1'b1, 4'($urandom_range(3, 0)), 8'($urandom), 1'b1, 1'b1, acc, drn, ov, word);
      if (drn) begin
        vectors++;
        if (exp_q.size() == 0 || word !== exp_q[0]) begin
          miscompares++; $display("[TB] FAIL stats_group[%0d]: got %h expected %h", i, word, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, ov, word);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    vectors++;
    if (stat_groups !== 16'd0 || stat_lines !== 16'd4) begin
      miscompares++; $display("[TB] FAIL stats_wrap: groups %0d lines %0d expected 0 4", stat_groups, stat_lines);
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_last();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
`ifdef FAN_PACK_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
